// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg: size codes and FSM state encoding for the load/store unit   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned ST_W = 1;
  localparam logic [ST_W-1:0] ST_IDLE   = 1'b0;
  localparam logic [ST_W-1:0] ST_RMW_WR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +----------------------------------------------------------------------+
// | lsu_lane_align: little-endian sub-word load extract/extend and store |
// | lane merge. Purely combinational. Rev 1.0                            |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    case (i_size)
      SZ_BYTE: o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_word;
    case (i_size)
      SZ_BYTE: o_merge[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      SZ_HALF: o_merge[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
      default: o_merge = i_word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit: byte-addressed MIPS loads/stores onto a word-only   |
// | memory; SB/SH use a stalling read-modify-write. Rev 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_mem_read,
  input  logic             i_mem_write,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_stall,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_fault,
  output logic [WIDTH-1:0] o_fault_addr,
  output logic [WIDTH-1:0] o_mem_address,
  output logic [WIDTH-1:0] o_mem_data,
  output logic             o_mem_we,
  output logic             o_mem_re,
  input  logic [WIDTH-1:0] i_mem_data
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [WIDTH-1:0] rdata_q, fault_addr_q, rmw_data_q, rmw_addr_q;
  logic             rvalid_q, fault_q;

  logic             w_misalign, w_fault, w_load, w_store, w_sub_store;
  logic [WIDTH-1:0] w_load_data, w_merge;

  always_comb begin
    w_misalign = (i_size == 2'b11)
              || (i_size == SZ_HALF && i_addr[0])
              || (i_size == SZ_WORD && i_addr[1:0] != 2'b00);
  end

  // Requests are only decoded in IDLE; RMW_WR ignores the upstream bus.
  assign w_fault     = (state_q == ST_IDLE) && i_valid && (i_mem_read || i_mem_write)
                     && (w_misalign || (i_mem_read && i_mem_write));
  assign w_load      = (state_q == ST_IDLE) && i_valid && i_mem_read && !w_fault;
  assign w_store     = (state_q == ST_IDLE) && i_valid && i_mem_write && !w_fault;
  assign w_sub_store = w_store && (i_size != SZ_WORD);

  lsu_lane_align u_align (
    .i_word     (i_mem_data),
    .i_addr_lo  (i_addr[1:0]),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .i_wdata    (i_wdata[15:0]),
    .o_load     (w_load_data),
    .o_merge    (w_merge)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_sub_store) state_d = ST_RMW_WR;
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_stall       = 1'b0;
    o_mem_re      = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_address = {2'b00, i_addr[WIDTH-1:2]};
    o_mem_data    = i_wdata;
    case (state_q)
      ST_IDLE: begin
        o_mem_re = w_load || w_sub_store;
        o_mem_we = w_store && !w_sub_store;
        o_stall  = w_sub_store;
      end
      ST_RMW_WR: begin
        o_mem_we      = 1'b1;
        o_mem_address = rmw_addr_q;
        o_mem_data    = rmw_data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      rmw_data_q   <= '0;
      rmw_addr_q   <= '0;
    end else begin
      rvalid_q <= w_load;
      fault_q  <= w_fault;
      if (w_load)      rdata_q      <= w_load_data;
      if (w_fault)     fault_addr_q <= i_addr;
      if (w_sub_store) begin
        rmw_data_q <= w_merge;
        rmw_addr_q <= {2'b00, i_addr[WIDTH-1:2]};
      end
    end
  end

  assign o_rdata      = rdata_q;
  assign o_rvalid     = rvalid_q;
  assign o_fault      = fault_q;
  assign o_fault_addr = fault_addr_q;

endmodule

`default_nettype wire
